// File: rtl/efpga_cfg_pkg.sv
// Shared constants for the eFPGA configuration loader: register offsets,
// CTRL/STATUS bit positions and the load FSM state type.
`timescale 1ns/1ps
package efpga_cfg_pkg;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_DATA    = 8'h08;
    localparam logic [7:0] OFF_WCOUNT  = 8'h0C;
    localparam logic [7:0] OFF_IO_SEL  = 8'h10;
    localparam logic [7:0] OFF_IO_OUT  = 8'h14;
    localparam logic [7:0] OFF_IO_OEB  = 8'h18;
    localparam logic [7:0] OFF_CHK_SUM = 8'h1C;
    localparam logic [7:0] OFF_CHK_EXP = 8'h20;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_DONE  = 3;
    localparam int unsigned ST_OVF   = 4;
    localparam int unsigned ST_ERR   = 5;

    localparam int unsigned WCNT_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_DONE      = 3'd3,
        S_ERROR     = 3'd4
    } cfg_state_e;

endpackage

// File: rtl/efpga_cfg_fifo.sv
// Synchronous bitstream FIFO with flush, level and first-word-fall-through head.
// A push while full is dropped even if a pop happens in the same cycle.
`timescale 1ns/1ps
module efpga_cfg_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/efpga_wb_cfg_loader.sv
// Wishbone-mapped eFPGA bitstream loader with status/IRQ and per-pad bypass mux.
// Optional checksum of streamed words is enabled with EFPGA_CFG_CHECKSUM_EN.
`timescale 1ns/1ps
module efpga_wb_cfg_loader
    import efpga_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NUM_IO     = 31
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [31:0]       cfg_data_o,
    output logic              cfg_valid_o,
    input  logic              cfg_ready_i,
    input  logic              cfg_done_i,
    input  logic [NUM_IO-1:0] fab_io_out_i,
    input  logic [NUM_IO-1:0] fab_io_oeb_i,
    output logic [NUM_IO-1:0] io_out_o,
    output logic [NUM_IO-1:0] io_oeb_o,
    output logic              irq_o
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    cfg_state_e          state_q, state_d;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic [WCNT_W-1:0]   wcount_q;
    logic [WCNT_W-1:0]   words_sent_q;
    logic                irq_en_q, done_q, ovf_q, err_q, irq_q;
    logic [NUM_IO-1:0]   io_sel_q, io_out_q, io_oeb_q;

    logic                in_range, acc, wr;
    logic [7:0]          off;
    logic                start, abort, push, w1c, pop;
    logic                busy, start_go, done_set, err_set, sum_ok;
    logic [WCNT_W-1:0]   sent_inc;
    logic [31:0]         rdata;
    logic [WORD_W-1:0]   fifo_head;
    logic                fifo_full, fifo_empty;
    logic [LVL_W-1:0]    fifo_level;
    logic                unused_sel;

    assign unused_sel = &{1'b0, wbs_sel_i};

    // Bus decode; a new access is only taken once the previous ack has dropped.
    assign in_range = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign off      = wbs_adr_i[7:0];
    assign acc      = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr       = acc & wbs_we_i & in_range;
    assign start    = wr & (off == OFF_CTRL) & wbs_dat_i[CTRL_START];
    assign abort    = wr & (off == OFF_CTRL) & wbs_dat_i[CTRL_ABORT];
    assign push     = wr & (off == OFF_DATA);
    assign w1c      = wr & (off == OFF_STATUS);

    assign busy     = (state_q == S_LOAD) || (state_q == S_WAIT_DONE);
    assign pop      = (state_q == S_LOAD) & ~fifo_empty & cfg_ready_i;
    assign sent_inc = words_sent_q + WCNT_W'(1);

    efpga_cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (abort),
        .push  (push),
        .wdata (wbs_dat_i),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef EFPGA_CFG_CHECKSUM_EN
    logic [31:0] sum_q, exp_q;
    assign sum_ok = (sum_q == exp_q);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sum_q <= '0;
            exp_q <= '0;
        end else begin
            if (abort || start_go) begin
                sum_q <= '0;
            end else if (pop) begin
                sum_q <= sum_q + fifo_head;
            end
            if (wr && off == OFF_CHK_EXP) begin
                exp_q <= wbs_dat_i;
            end
        end
    end
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over everything; a start from DONE/ERROR goes straight to LOAD.
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        start_go = 1'b1;
                        if (wcount_q != '0) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_ERROR;
                            err_set = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (pop && sent_inc == wcount_q) begin
                        state_d = S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (cfg_done_i) begin
                        if (sum_ok) begin
                            state_d  = S_DONE;
                            done_set = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                            err_set = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            wcount_q     <= '0;
            words_sent_q <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            io_sel_q     <= '0;
            io_out_q     <= '0;
            io_oeb_q     <= '1;
        end else begin
            ack_q <= wbs_stb_i & wbs_cyc_i & ~ack_q;
            dat_q <= (acc && !wbs_we_i) ? rdata : '0;
            irq_q <= irq_en_q & (done_q | err_q | ovf_q);

            if (abort || start_go) begin
                words_sent_q <= '0;
            end else if (pop) begin
                words_sent_q <= sent_inc;
            end

            // Sticky status: a same-cycle set beats a W1C clear.
            if (done_set) begin
                done_q <= 1'b1;
            end else if (w1c && wbs_dat_i[ST_DONE]) begin
                done_q <= 1'b0;
            end
            if (push && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (w1c && wbs_dat_i[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (w1c && wbs_dat_i[ST_ERR]) begin
                err_q <= 1'b0;
            end

            if (wr) begin
                case (off)
                    OFF_CTRL:   irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
                    OFF_WCOUNT: wcount_q <= wbs_dat_i[WCNT_W-1:0];
                    OFF_IO_SEL: io_sel_q <= wbs_dat_i[NUM_IO-1:0];
                    OFF_IO_OUT: io_out_q <= wbs_dat_i[NUM_IO-1:0];
                    OFF_IO_OEB: io_oeb_q <= wbs_dat_i[NUM_IO-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (in_range) begin
            case (off)
                OFF_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
                OFF_STATUS: begin
                    rdata[ST_BUSY]  = busy;
                    rdata[ST_FULL]  = fifo_full;
                    rdata[ST_EMPTY] = fifo_empty;
                    rdata[ST_DONE]  = done_q;
                    rdata[ST_OVF]   = ovf_q;
                    rdata[ST_ERR]   = err_q;
                    rdata[15:8]     = 8'(fifo_level);
                    rdata[31:16]    = words_sent_q;
                end
                OFF_WCOUNT: rdata = 32'(wcount_q);
                OFF_IO_SEL: rdata = 32'(io_sel_q);
                OFF_IO_OUT: rdata = 32'(io_out_q);
                OFF_IO_OEB: rdata = 32'(io_oeb_q);
`ifdef EFPGA_CFG_CHECKSUM_EN
                OFF_CHK_SUM: rdata = sum_q;
                OFF_CHK_EXP: rdata = exp_q;
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign irq_o       = irq_q;
    assign cfg_valid_o = (state_q == S_LOAD) & ~fifo_empty;
    assign cfg_data_o  = cfg_valid_o ? fifo_head : '0;
    assign io_out_o    = (io_sel_q & fab_io_out_i) | (~io_sel_q & io_out_q);
    assign io_oeb_o    = (io_sel_q & fab_io_oeb_i) | (~io_sel_q & io_oeb_q);

endmodule

// File: tb/tb_efpga_wb_cfg_loader.sv
// Directed self-checking bench for efpga_wb_cfg_loader (both with and
// without EFPGA_CFG_CHECKSUM_EN).
`timescale 1ns/1ps
module tb_efpga_wb_cfg_loader;

    localparam int unsigned NUM_IO = 31;
    localparam logic [31:0] B      = 32'h3000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              stb, cyc, we;
    logic [3:0]        sel;
    logic [31:0]       adr, wdat;
    logic              ack;
    logic [31:0]       rdat_o;
    logic [31:0]       cfg_data;
    logic              cfg_valid;
    logic              cfg_ready, cfg_done;
    logic [NUM_IO-1:0] fab_out, fab_oeb, io_out, io_oeb;
    logic              irq;

    int checks = 0;
    int errors = 0;

    efpga_wb_cfg_loader #(
        .BASE_ADR   (B),
        .FIFO_DEPTH (8),
        .NUM_IO     (NUM_IO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat_o),
        .cfg_data_o   (cfg_data),
        .cfg_valid_o  (cfg_valid),
        .cfg_ready_i  (cfg_ready),
        .cfg_done_i   (cfg_done),
        .fab_io_out_i (fab_out),
        .fab_io_oeb_i (fab_oeb),
        .io_out_o     (io_out),
        .io_oeb_o     (io_oeb),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic got);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        got = 1'b0;
        r   = 'x;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                r   = rdat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        got;
        xfer(1'b1, a, d, r, got);
        chk("wr_ack", 32'(got), 32'h1);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        got;
        xfer(1'b0, a, 32'h0, r, got);
        chk({tag, "_ack"}, 32'(got), 32'h1);
        chk(tag, r, exp);
    endtask

    task automatic step(input logic rdy);
        cfg_ready = rdy;
        @(posedge clk); #1;
        cfg_ready = 1'b0;
    endtask

    task automatic pulse_done();
        cfg_done = 1'b1;
        @(posedge clk); #1;
        cfg_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        adr = '0; wdat = '0; cfg_ready = 1'b0; cfg_done = 1'b0;
        fab_out = '0; fab_oeb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(cfg_valid), 32'h0);
        chk("rst_data", cfg_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_oeb", 32'(io_oeb), 32'h7FFF_FFFF);
        chk("rst_out", 32'(io_out), 32'h0);
        rd("rst_status", B + 32'h04, 32'h0000_0004);

        // Normal load of three words with irq enabled
        wr(B + 32'h0C, 32'd3);
        wr(B + 32'h08, 32'hA1);
        wr(B + 32'h08, 32'hB2);
        wr(B + 32'h08, 32'hC3);
        rd("pre_status", B + 32'h04, 32'h0000_0300);
        wr(B + 32'h00, 32'h5);
        chk("n_v0", 32'(cfg_valid), 32'h1);
        chk("n_d0", cfg_data, 32'hA1);
        cfg_ready = 1'b1;
        @(posedge clk); #1;
        chk("n_d1", cfg_data, 32'hB2);
        @(posedge clk); #1;
        chk("n_d2", cfg_data, 32'hC3);
        @(posedge clk); #1;
        chk("n_v3", 32'(cfg_valid), 32'h0);
        cfg_ready = 1'b0;
        rd("n_wait", B + 32'h04, 32'h0003_0005);
        pulse_done();
        rd("n_done", B + 32'h04, 32'h0003_000C);
        chk("n_irq", 32'(irq), 32'h1);
        wr(B + 32'h04, 32'h8);
        rd("n_w1c", B + 32'h04, 32'h0003_0004);
        chk("n_irq_clr", 32'(irq), 32'h0);

        // Backpressure and mid-load empty stall
        wr(B + 32'h0C, 32'd4);
        wr(B + 32'h08, 32'h11);
        wr(B + 32'h08, 32'h22);
        wr(B + 32'h00, 32'h1);
        chk("b_d0", cfg_data, 32'h11);
        step(1'b1);
        chk("b_d1", cfg_data, 32'h22);
        step(1'b0);
        chk("b_stall_v", 32'(cfg_valid), 32'h1);
        chk("b_stall_d", cfg_data, 32'h22);
        step(1'b1);
        chk("b_empty_v", 32'(cfg_valid), 32'h0);
        step(1'b0);
        chk("b_empty_v2", 32'(cfg_valid), 32'h0);
        wr(B + 32'h08, 32'h33);
        chk("b_d2", cfg_data, 32'h33);
        step(1'b1);
        chk("b_empty_v3", 32'(cfg_valid), 32'h0);
        wr(B + 32'h08, 32'h44);
        chk("b_d3", cfg_data, 32'h44);
        step(1'b1);
        rd("b_wait", B + 32'h04, 32'h0004_0005);
        pulse_done();
        rd("b_done", B + 32'h04, 32'h0004_000C);
        wr(B + 32'h04, 32'h8);

        // Overflow: nine writes into an eight-entry FIFO
        wr(B + 32'h00, 32'h2);
        for (int i = 0; i < 9; i++) begin
            wr(B + 32'h08, 32'h100 + 32'(i));
        end
        rd("o_status", B + 32'h04, 32'h0000_0812);
        wr(B + 32'h0C, 32'd8);
        wr(B + 32'h00, 32'h1);
        cfg_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("o_v", 32'(cfg_valid), 32'h1);
            chk("o_d", cfg_data, 32'h100 + 32'(i));
            @(posedge clk); #1;
        end
        chk("o_no9th", 32'(cfg_valid), 32'h0);
        cfg_ready = 1'b0;
        rd("o_wait", B + 32'h04, 32'h0008_0015);

        // Abort after two of five words
        wr(B + 32'h04, 32'h10);
        wr(B + 32'h00, 32'h2);
        wr(B + 32'h0C, 32'd5);
        for (int i = 0; i < 5; i++) begin
            wr(B + 32'h08, 32'h51 + 32'(i));
        end
        wr(B + 32'h00, 32'h1);
        step(1'b1);
        step(1'b1);
        rd("a_mid", B + 32'h04, 32'h0002_0301);
        wr(B + 32'h00, 32'h2);
        chk("a_valid", 32'(cfg_valid), 32'h0);
        rd("a_status", B + 32'h04, 32'h0000_0004);

        // Start with zero word count is an error
        wr(B + 32'h0C, 32'd0);
        wr(B + 32'h00, 32'h1);
        rd("e_status", B + 32'h04, 32'h0000_0024);
        wr(B + 32'h00, 32'h4);
        rd("e_ctrl", B + 32'h00, 32'h0000_0004);
        chk("e_irq", 32'(irq), 32'h1);
        wr(B + 32'h04, 32'h20);
        rd("e_w1c", B + 32'h04, 32'h0000_0004);
        chk("e_irq_clr", 32'(irq), 32'h0);
        wr(B + 32'h00, 32'h2);

        // Unmapped and out-of-range accesses
        rd("u_unmapped", B + 32'h40, 32'h0);
        rd("u_range", B + 32'h104, 32'h0);
        rd("u_data_wo", B + 32'h08, 32'h0);
        wr(B + 32'h108, 32'hDEAD);
        rd("u_nopush", B + 32'h04, 32'h0000_0004);

`ifdef EFPGA_CFG_CHECKSUM_EN
        // Wrong expected checksum ends in ERROR
        wr(B + 32'h0C, 32'd1);
        wr(B + 32'h20, 32'h1);
        wr(B + 32'h08, 32'h10);
        wr(B + 32'h00, 32'h1);
        step(1'b1);
        rd("c_sum", B + 32'h1C, 32'h10);
        pulse_done();
        rd("c_err", B + 32'h04, 32'h0001_0024);
`else
        rd("c_sum_unmapped", B + 32'h1C, 32'h0);
        wr(B + 32'h20, 32'h1);
        rd("c_exp_unmapped", B + 32'h20, 32'h0);
        wr(B + 32'h0C, 32'd1);
        wr(B + 32'h08, 32'h10);
        wr(B + 32'h00, 32'h1);
        step(1'b1);
        pulse_done();
        rd("c_done", B + 32'h04, 32'h0001_000C);
`endif
        wr(B + 32'h00, 32'h2);
        wr(B + 32'h04, 32'h38);

        // Pad mux
        fab_out = '1;
        fab_oeb = '1;
        wr(B + 32'h10, 32'h1);
        wr(B + 32'h14, 32'h2);
        wr(B + 32'h18, 32'h0);
        chk("p_out", 32'(io_out), 32'h3);
        chk("p_oeb", 32'(io_oeb), 32'h1);
        rd("p_sel", B + 32'h10, 32'h1);

        // Reset in the middle of a load
        wr(B + 32'h0C, 32'd2);
        wr(B + 32'h08, 32'h77);
        wr(B + 32'h08, 32'h88);
        wr(B + 32'h00, 32'h1);
        chk("r_v_before", 32'(cfg_valid), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("r_valid", 32'(cfg_valid), 32'h0);
        chk("r_data", cfg_data, 32'h0);
        chk("r_oeb", 32'(io_oeb), 32'h7FFF_FFFF);
        rst = 1'b0;
        rd("r_status", B + 32'h04, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
